// File: rtl/mem_bus_scheduler.sv
// mem_bus_scheduler: arbitrates the shared memory bus between fetch and load/store.
// Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_bus_scheduler #(
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instr_address_in,
   input  logic        instr_read_in,
   output logic [31:0] instr_read_value_out,
   output logic        instr_ready,
   input  logic [31:0] data_address_in,
   input  logic        data_read_in,
   input  logic        data_write_in,
   input  logic [3:0]  data_write_mask_in,
   input  logic [31:0] data_write_value_in,
   output logic [31:0] data_read_value_out,
   output logic        data_ready,
   output logic [31:0] address_out,
   output logic        read_out,
   output logic        write_out,
   output logic [3:0]  write_mask_out,
   output logic [31:0] write_value_out,
   input  logic [31:0] read_value_in,
   input  logic        ready_in,
   output logic        bus_error_out
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
      $error("STARVE_LIMIT out of range 1..15");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 2..255");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      INSTR = 2'd1,
      DATA  = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state;
   logic [3:0] starve_cnt;

   logic data_req;
   logic force_instr;
   logic instr_act;
   logic data_act;
   logic timeout_hit;
   logic done;

   assign data_req    = data_read_in | data_write_in;
   assign force_instr = instr_read_in && (starve_cnt == LIMIT);
   // a grant only drives the bus while its master keeps requesting
   assign instr_act   = (state == INSTR) && instr_read_in;
   assign data_act    = (state == DATA) && data_req;

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wait_cnt;

   assign timeout_hit = (instr_act | data_act) && !ready_in
                        && (wait_cnt == TO_LAST);

   // wait-state counter: zero while idle, counts stalled grant cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 8'd0;
      end else if (state == IDLE) begin
         wait_cnt <= 8'd0;
      end else if (!ready_in) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign done          = ready_in | timeout_hit;
   assign bus_error_out = timeout_hit;

   // grant state and starvation tracking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (data_req && !force_instr) begin
                  state <= DATA;
                  if (instr_read_in && starve_cnt < LIMIT) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
               end else if (instr_read_in) begin
                  state      <= INSTR;
                  starve_cnt <= 4'd0;
               end
            end
            INSTR: begin
               if (!instr_read_in || done) begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (!data_req || done) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // bus and master-side routing for the current grant
   always_comb begin
      address_out          = 32'd0;
      read_out             = 1'b0;
      write_out            = 1'b0;
      write_mask_out       = 4'd0;
      write_value_out      = 32'd0;
      instr_read_value_out = 32'd0;
      instr_ready          = 1'b0;
      data_read_value_out  = 32'd0;
      data_ready           = 1'b0;
      if (instr_act) begin
         address_out          = instr_address_in;
         read_out             = 1'b1;
         instr_ready          = done;
         instr_read_value_out = timeout_hit ? 32'hFFFF_FFFF
                                            : read_value_in;
      end
      if (data_act) begin
         address_out         = data_address_in;
         read_out            = data_read_in;
         write_out           = data_write_in;
         write_mask_out      = data_write_mask_in;
         write_value_out     = data_write_value_in;
         data_ready          = done;
         data_read_value_out = timeout_hit ? 32'hFFFF_FFFF
                                           : read_value_in;
      end
   end

endmodule

// File: doc/mem_bus_scheduler.md
Name: mem_bus_scheduler

Overview:
Registered, multi-cycle arbiter that shares the single common memory bus between the instruction-fetch master and the load/store master.
- Unlike a purely combinational mux, it holds a grant for the whole transaction until the memory side signals `ready_in`, so slow memories and peripherals can insert wait states.
- Data accesses have priority. A starvation counter forces an instruction fetch after `STARVE_LIMIT` consecutive data grants that occurred while a fetch was pending.
- Sits between the CPU core's two memory ports and the memory/peripheral interconnect.

Parameters:
- `STARVE_LIMIT`, 4: consecutive data grants with a fetch pending before the fetch is forced; range 1..15.
- `TIMEOUT_CYCLES`, 64: wait cycles before a forced completion; used only with `BUS_TIMEOUT_EN`; range 2..255.

Ports:
- `clk`, in, 1: clock; all state on rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `instr_address_in`, in, 32: fetch address.
- `instr_read_in`, in, 1: fetch request; held until `instr_ready`.
- `instr_read_value_out`, out, 32: fetch data, valid when `instr_ready`=1.
- `instr_ready`, out, 1: fetch complete, one-cycle pulse.
- `data_address_in`, in, 32: load/store address.
- `data_read_in`, in, 1: load request; held until `data_ready`.
- `data_write_in`, in, 1: store request; held until `data_ready`.
- `data_write_mask_in`, in, 4: store byte enables.
- `data_write_value_in`, in, 32: store data.
- `data_read_value_out`, out, 32: load data, valid when `data_ready`=1.
- `data_ready`, out, 1: load/store complete, one-cycle pulse.
- `address_out`, out, 32: common bus address.
- `read_out`, out, 1: common bus read strobe.
- `write_out`, out, 1: common bus write strobe.
- `write_mask_out`, out, 4: common bus byte enables.
- `write_value_out`, out, 32: common bus write data.
- `read_value_in`, in, 32: common bus read data.
- `ready_in`, in, 1: slave completes the current access this cycle.
- `bus_error_out`, out, 1: timeout pulse; tied 0 without `BUS_TIMEOUT_EN`.

Behaviour:
- **State machine:** states `IDLE`, `INSTR`, `DATA`; 2-bit state register plus starvation counter `starve_cnt` (4 bits).
- **Reset:** `reset_n`=0 asynchronously sets state `IDLE`, `starve_cnt`=0, timeout counter=0.
  - All outputs are 0, including `address_out`, `write_value_out` and both read-value outputs; no X is ever driven.
  - Reset in the middle of a transaction simply abandons it; no ready pulse is issued.
- **`IDLE`:** all bus and ready outputs are 0. Arbitration runs on the registered inputs of this cycle:
  - If the data master requests (`data_read_in` or `data_write_in`) and no fetch is forced, next state is `DATA`.
  - A fetch is forced when `instr_read_in`=1 and `starve_cnt`=`STARVE_LIMIT`; next state is `INSTR`.
  - If only `instr_read_in` is asserted, next state is `INSTR`.
  - If there are no requests, stay in `IDLE`.
- **Starvation counter:**
  - Increments, saturating at `STARVE_LIMIT`, on each `DATA` grant taken while `instr_read_in`=1.
  - Clears on every `INSTR` grant.
  - Unchanged on a `DATA` grant with no fetch pending.
- **Grant latency:** one cycle from request to bus strobe. A request first seen in cycle N produces the bus strobe in cycle N+1.
- **`DATA` state:**
  - `address_out`, `read_out`, `write_out`, `write_mask_out` and `write_value_out` pass straight through from the data master inputs.
  - `data_read_value_out` = `read_value_in`; `data_ready` = `ready_in`.
- **`INSTR` state:**
  - `address_out` = `instr_address_in`; `read_out`=1; `write_out`=0; `write_mask_out`=0; `write_value_out`=0.
  - `instr_read_value_out` = `read_value_in`; `instr_ready` = `ready_in`.
- **Completion:** `ready_in`=1 in `INSTR`/`DATA` ends the transaction; next state is `IDLE`. There is therefore one idle bubble between back-to-back transactions, which lets the master drop or change its request.
- **Abort:** if the granted master deasserts its request before `ready_in`, bus strobes drop that same cycle, no ready pulse is issued, and next state is `IDLE`.
- **Ungranted master:** its ready output is held 0 and its read-value output is 0.
- **Simultaneous `data_read_in` and `data_write_in`:** both strobes are forwarded unchanged; protocol legality is the master's responsibility.
- **`ready_in` in `IDLE`:** ignored.

Optional Feature:
- **With `BUS_TIMEOUT_EN` defined:**
  - A timeout counter clears on entry to `INSTR`/`DATA` and increments each cycle without `ready_in`.
  - When it reaches `TIMEOUT_CYCLES`-1 without `ready_in`, that cycle forces completion:
    - the granted master's ready = 1;
    - its read-value output = 32'hFFFF_FFFF;
    - `bus_error_out` = 1 for that cycle;
    - next state is `IDLE`.
- **Without it:** a transaction waits indefinitely for `ready_in`; `bus_error_out` is constant 0 and no counter is instantiated.

Test Plan:
- **Single fetch:** `instr_read_in`=1, addr 0x100, `ready_in`=1 two cycles later, `read_value_in`=0x00000013 -> `read_out`=1 from cycle 1; `instr_ready`=1 and `instr_read_value_out`=0x00000013 in cycle 3; state `IDLE` in cycle 4.
- **Wait states and simultaneous request:** data store at 0x2000, mask 4'b0011, value 0xDEADBEEF, issued in the same cycle as a fetch; slave holds off 3 cycles -> `DATA` granted first; `write_out`=1 and `write_mask_out`=0011 for 4 cycles; then `data_ready` pulse; fetch granted after the bubble.
- **Starvation:** `instr_read_in` held high; data requests back-to-back with 1-cycle slaves; `STARVE_LIMIT`=4 -> exactly 4 `DATA` grants, then `INSTR`; `starve_cnt` returns to 0.
- **Abort:** data load granted, `data_read_in` dropped before `ready_in` -> `read_out`=0 that cycle, `data_ready` never pulses, `IDLE` next cycle.
- **Reset mid-transaction:** `reset_n` low during `DATA` wait -> all outputs 0 immediately (asynchronous); after release, a pending fetch is granted on the first clock.
- **`BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, slave never ready:** `bus_error_out`=1, `instr_ready`=1 and `instr_read_value_out`=0xFFFFFFFF in the 8th cycle of the grant; without the macro, the bus stays granted for 100+ cycles.
